adc_avg_filter: RTL and testbench

- Front-end conditioning stage between the analog network's 12-bit ADC bus and the frequency optimization block.
- Waits for the analog path to settle after each frequency step, decimates the ADC bus, and averages 2^LOG2_N samples.
- Publishes one averaged value per window with a single-cycle valid strobe, plus the window peak.
- Lets the frequency algorithm compare stable, noise-reduced readings instead of raw per-clock ADC values.

---
 rtl/adc_avg_filter.sv | 172 +++++++++++++++++
 tb/tb_adc_avg_filter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_avg_filter.sv
// adc_avg_filter: settles after each enable/frequency step, decimates the ADC bus by SAMPLE_DIV,
// and publishes the truncated average and the peak of every 2^LOG2_N samples with a one-cycle
// strobe. Windows run back to back until enable drops or freq_changed forces a re-settle.
// Optional: define ADC_SYNC_EN to pass adc_in through a two-flop synchronizer before sampling.
module adc_avg_filter #(
  parameter int unsigned ADC_W      = 12,
  parameter int unsigned LOG2_N     = 4,
  parameter int unsigned SAMPLE_DIV = 50,
  parameter int unsigned SETTLE_CYC = 1000
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             enable,
  input  logic             freq_changed,
  input  logic [ADC_W-1:0] adc_in,
  output logic [ADC_W-1:0] avg_out,
  output logic [ADC_W-1:0] peak_out,
  output logic             avg_valid,
  output logic             busy
);

  localparam int unsigned N     = 1 << LOG2_N;
  localparam int unsigned ACC_W = ADC_W + LOG2_N;
  localparam int unsigned CNT_W = LOG2_N + 1;
  localparam int unsigned DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int unsigned SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StSettle = 2'd1;
  localparam logic [1:0] StAccum  = 2'd2;
  localparam logic [1:0] StDone   = 2'd3;

  localparam logic [SET_W-1:0] SettleLoad = SET_W'(SETTLE_CYC - 1);
  localparam logic [DIV_W-1:0] DivLast    = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [CNT_W-1:0] CntLast    = CNT_W'(N - 1);

  logic [1:0]       state_q, state_d;
  logic [SET_W-1:0] settle_q, settle_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ADC_W-1:0] peak_q, peak_d;
  logic [ADC_W-1:0] avg_q, avg_d;
  logic [ADC_W-1:0] peak_out_q, peak_out_d;
  logic             valid_q, valid_d;
  logic [ADC_W-1:0] sample;

`ifdef ADC_SYNC_EN
  logic [ADC_W-1:0] sync1_q, sync2_q;

  // Two-flop synchronizer: each sample is adc_in as it was two edges earlier.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= adc_in;
      sync2_q <= sync1_q;
    end
  end

  assign sample = sync2_q;
`else
  assign sample = adc_in;
`endif

  // Next-state logic: window sequencing first, then enable/freq_changed overrides.
  always_comb begin
    state_d    = state_q;
    settle_d   = settle_q;
    div_d      = div_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    peak_d     = peak_q;
    avg_d      = avg_q;
    peak_out_d = peak_out_q;
    valid_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (enable) begin
          state_d  = StSettle;
          settle_d = SettleLoad;
        end
      end
      StSettle: begin
        if (settle_q == '0) begin
          state_d = StAccum;
          div_d   = '0;
          cnt_d   = '0;
          acc_d   = '0;
          peak_d  = '0;
        end else begin
          settle_d = settle_q - SET_W'(1);
        end
      end
      StAccum: begin
        if (div_q == DivLast) begin
          div_d = '0;
          acc_d = acc_q + ACC_W'(sample);
          cnt_d = cnt_q + CNT_W'(1);
          if (sample > peak_q) begin
            peak_d = sample;
          end
          if (cnt_q == CntLast) begin
            state_d = StDone;
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      StDone: begin
        avg_d      = acc_q[ACC_W-1:LOG2_N];
        peak_out_d = peak_q;
        valid_d    = 1'b1;
        state_d    = StAccum;
        div_d      = '0;
        cnt_d      = '0;
        acc_d      = '0;
        peak_d     = '0;
      end
      default: state_d = StIdle;
    endcase

    // A dropped enable or a frequency step abandons the window, including a pending DONE update.
    if (state_q != StIdle) begin
      if (!enable) begin
        state_d    = StIdle;
        avg_d      = avg_q;
        peak_out_d = peak_out_q;
        valid_d    = 1'b0;
      end else if (freq_changed) begin
        state_d    = StSettle;
        settle_d   = SettleLoad;
        avg_d      = avg_q;
        peak_out_d = peak_out_q;
        valid_d    = 1'b0;
      end
    end
  end

  // State, counters, accumulator and published results.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= StIdle;
      settle_q   <= '0;
      div_q      <= '0;
      cnt_q      <= '0;
      acc_q      <= '0;
      peak_q     <= '0;
      avg_q      <= '0;
      peak_out_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      settle_q   <= settle_d;
      div_q      <= div_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      peak_q     <= peak_d;
      avg_q      <= avg_d;
      peak_out_q <= peak_out_d;
      valid_q    <= valid_d;
    end
  end

  assign avg_out   = avg_q;
  assign peak_out  = peak_out_q;
  assign avg_valid = valid_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_adc_avg_filter.sv
// Bench for adc_avg_filter with SETTLE_CYC=4, SAMPLE_DIV=2, LOG2_N=2 and the synchronizer off.
// A schedule-based reference model checks every cycle; table windows and hand sequences add
// direct checks of latency, averaging, hold and abort behaviour.
module tb_adc_avg_filter;

  localparam int ADC_W  = 12;
  localparam int LOG2_N = 2;
  localparam int N      = 4;
  localparam int DIV    = 2;
  localparam int SETTLE = 4;

  typedef struct packed {
    logic [3:0][11:0] s;
    logic [11:0]      avg;
    logic [11:0]      peak;
  } vec_t;

  logic             clk = 1'b0;
  logic             nrst;
  logic             enable;
  logic             freq_changed;
  logic [ADC_W-1:0] adc_in;
  logic [ADC_W-1:0] avg_out;
  logic [ADC_W-1:0] peak_out;
  logic             avg_valid;
  logic             busy;

  int errors = 0;
  int checks = 0;

  adc_avg_filter #(
    .ADC_W     (ADC_W),
    .LOG2_N    (LOG2_N),
    .SAMPLE_DIV(DIV),
    .SETTLE_CYC(SETTLE)
  ) dut (
    .clk         (clk),
    .nrst        (nrst),
    .enable      (enable),
    .freq_changed(freq_changed),
    .adc_in      (adc_in),
    .avg_out     (avg_out),
    .peak_out    (peak_out),
    .avg_valid   (avg_valid),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Reference model: window timing derived from the restart edge, samples kept in a queue.
  int          edge_n = 0;
  bit          m_active;
  int          win_ref;
  int          samples[$];
  logic [11:0] m_avg;
  logic [11:0] m_peak;
  bit          m_valid;

  task automatic model_reset();
    m_active = 0;
    m_valid  = 0;
    m_avg    = '0;
    m_peak   = '0;
    win_ref  = 0;
    samples.delete();
  endtask

  task automatic model_edge(input int n, input bit en, input bit fc, input logic [11:0] adc);
    int sum;
    int mx;
    m_valid = 0;
    if (!m_active) begin
      if (en) begin
        m_active = 1;
        win_ref  = n + SETTLE;
        samples.delete();
      end
    end else if (!en) begin
      m_active = 0;
    end else if (fc) begin
      win_ref = n + SETTLE;
      samples.delete();
    end else if (n == win_ref + N * DIV + 1) begin
      sum = 0;
      mx  = 0;
      foreach (samples[i]) begin
        sum += samples[i];
        if (samples[i] > mx) mx = samples[i];
      end
      m_avg   = 12'(sum / N);
      m_peak  = 12'(mx);
      m_valid = 1;
      win_ref = n;
      samples.delete();
    end else if (n > win_ref && ((n - win_ref) % DIV) == 0) begin
      samples.push_back(int'(adc));
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  // One clock: drive inputs, take the edge, update the model, compare 1 time unit later.
  task automatic step(input bit en, input bit fc, input logic [11:0] adc);
    enable       = en;
    freq_changed = fc;
    adc_in       = adc;
    @(posedge clk);
    edge_n++;
    model_edge(edge_n, en, fc, adc);
    #1;
    check("model_valid", {31'd0, avg_valid}, {31'd0, m_valid});
    check("model_avg", {20'd0, avg_out}, {20'd0, m_avg});
    check("model_peak", {20'd0, peak_out}, {20'd0, m_peak});
    check("model_busy", {31'd0, busy}, {31'd0, m_active});
  endtask

  // Counts edges (the first may carry freq_changed) until a strobe, bounded.
  task automatic wait_strobe(input bit fc_first, input logic [11:0] adc, output int n);
    n = 0;
    do begin
      step(1'b1, (n == 0) ? fc_first : 1'b0, adc);
      n++;
    end while (!avg_valid && n < 60);
  endtask

  function automatic vec_t mk(input logic [11:0] a, input logic [11:0] b, input logic [11:0] c,
                              input logic [11:0] d, input logic [11:0] av, input logic [11:0] pk);
    vec_t v;
    v.s[0] = a;
    v.s[1] = b;
    v.s[2] = c;
    v.s[3] = d;
    v.avg  = av;
    v.peak = pk;
    return v;
  endfunction

  initial begin
    vec_t vecs[7];
    int   n;
    bit   en_r;
    int   off_cnt;

    vecs[0] = mk(12'h800, 12'h800, 12'h800, 12'h800, 12'h800, 12'h800);
    vecs[1] = mk(12'h100, 12'h200, 12'h300, 12'h403, 12'h280, 12'h403);
    vecs[2] = mk(12'h000, 12'h000, 12'h000, 12'h003, 12'h000, 12'h003);
    vecs[3] = mk(12'h001, 12'h002, 12'h003, 12'h005, 12'h002, 12'h005);
    vecs[4] = mk(12'hABC, 12'h000, 12'h000, 12'h000, 12'h2AF, 12'hABC);
    vecs[5] = mk(12'h7FF, 12'h800, 12'h7FF, 12'h800, 12'h7FF, 12'h800);
    vecs[6] = mk(12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF);

    model_reset();
    nrst         = 1'b0;
    enable       = 1'b0;
    freq_changed = 1'b0;
    adc_in       = '0;
    #12;
    check("rst_avg", {20'd0, avg_out}, 32'd0);
    check("rst_peak", {20'd0, peak_out}, 32'd0);
    check("rst_valid", {31'd0, avg_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    nrst = 1'b1;
    step(1'b0, 1'b0, 12'h800);
    step(1'b0, 1'b1, 12'h800);

    // Constant input: first strobe 14 edges after enable, then every 9.
    wait_strobe(1'b0, 12'h800, n);
    check("first_latency", n, 14);
    check("first_avg", {20'd0, avg_out}, 32'h800);
    check("first_peak", {20'd0, peak_out}, 32'h800);
    wait_strobe(1'b0, 12'h800, n);
    check("window_spacing", n, 9);

    // Back-to-back table windows: sample edges fall at offsets 2,4,6,8 after each strobe.
    for (int i = 0; i < 7; i++) begin
      for (int k = 1; k <= 9; k++) begin
        step(1'b1, 1'b0, (k <= 8) ? vecs[i].s[(k - 1) / 2] : 12'h000);
      end
      check($sformatf("vec%0d_valid", i), {31'd0, avg_valid}, 32'd1);
      check($sformatf("vec%0d_avg", i), {20'd0, avg_out}, {20'd0, vecs[i].avg});
      check($sformatf("vec%0d_peak", i), {20'd0, peak_out}, {20'd0, vecs[i].peak});
    end

    // freq_changed after two samples: window dropped, re-settle, 0xFFF held meanwhile.
    for (int k = 1; k <= 4; k++) step(1'b1, 1'b0, 12'h123);
    wait_strobe(1'b1, 12'h123, n);
    check("fc_mid_latency", n, 14);
    check("fc_mid_avg", {20'd0, avg_out}, 32'h123);

    // freq_changed on the DONE cycle suppresses the strobe and the update.
    for (int k = 1; k <= 8; k++) step(1'b1, 1'b0, 12'h456);
    step(1'b1, 1'b1, 12'h456);
    check("fc_done_valid", {31'd0, avg_valid}, 32'd0);
    check("fc_done_avg", {20'd0, avg_out}, 32'h123);
    check("fc_done_busy", {31'd0, busy}, 32'd1);
    wait_strobe(1'b0, 12'h456, n);
    check("fc_done_resettle", n, 13);
    check("fc_done_new_avg", {20'd0, avg_out}, 32'h456);

    // enable drop mid-window, then re-enable.
    for (int k = 1; k <= 3; k++) step(1'b1, 1'b0, 12'h111);
    step(1'b0, 1'b0, 12'h111);
    check("drop_busy", {31'd0, busy}, 32'd0);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 12'h111);
    check("drop_hold_avg", {20'd0, avg_out}, 32'h456);
    wait_strobe(1'b0, 12'h789, n);
    check("reenable_latency", n, 14);
    check("reenable_avg", {20'd0, avg_out}, 32'h789);

    // Asynchronous reset mid-window.
    for (int k = 1; k <= 5; k++) step(1'b1, 1'b0, 12'h222);
    #2;
    nrst = 1'b0;
    model_reset();
    #1;
    check("arst_avg", {20'd0, avg_out}, 32'd0);
    check("arst_peak", {20'd0, peak_out}, 32'd0);
    check("arst_valid", {31'd0, avg_valid}, 32'd0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    #2;
    nrst = 1'b1;
    wait_strobe(1'b0, 12'h321, n);
    check("arst_latency", n, 14);
    check("arst_new_avg", {20'd0, avg_out}, 32'h321);

    // Randomized run against the model.
    en_r    = 1;
    off_cnt = 0;
    for (int c = 0; c < 3000; c++) begin
      if (off_cnt > 0) begin
        off_cnt--;
        en_r = (off_cnt == 0);
      end else if ($urandom_range(0, 299) == 0) begin
        en_r    = 0;
        off_cnt = $urandom_range(1, 5);
      end
      step(en_r, ($urandom_range(0, 39) == 0), 12'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
